mmio_responder: RTL and testbench

// Memory-mapped I/O responder for the CPU data port: serves loads/stores to addr[31]=1 (0x8000_00xx).

---
 rtl/mmio_responder_pkg.sv | 15 +
 rtl/mmio_responder_if.sv | 24 ++
 rtl/mmio_rx_fifo.sv | 39 +++
 rtl/mmio_responder.sv | 74 +++++++
 tb/tb_mmio_responder.sv | 124 ++++++++++++
 5 files changed

// File: rtl/mmio_responder_pkg.sv
// mmio_responder_pkg: MMIO register map, status bit positions and TX state type
package mmio_responder_pkg;
    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYC    = 8'h10;
    localparam logic [7:0] OFF_INSTR  = 8'h14;
    localparam logic [7:0] OFF_CLR    = 8'h18;
    localparam int ST_TX_READY    = 0;
    localparam int ST_RX_NONEMPTY = 1;
    typedef enum logic {TX_IDLE, TX_PEND} tx_state_t;
    function automatic logic is_mmio(input logic [31:0] a, input int msb);
        return a[msb];
    endfunction
endpackage

// File: rtl/mmio_responder_if.sv
// mmio_responder_if: CPU data-port and UART ready/valid signals of the MMIO responder
interface mmio_responder_if;
    logic        req_valid;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic        inst_retire;
    logic [31:0] dout;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    modport master (
        output req_valid, addr, re, we, wdata, inst_retire, rx_data, rx_data_valid, tx_data_ready,
        input  dout, rx_data_ready, tx_data, tx_data_valid
    );
    modport slave (
        input  req_valid, addr, re, we, wdata, inst_retire, rx_data, rx_data_valid, tx_data_ready,
        output dout, rx_data_ready, tx_data, tx_data_valid
    );
endinterface

// File: rtl/mmio_rx_fifo.sv
// mmio_rx_fifo: synchronous byte FIFO; a push is still taken when full if a pop happens the same cycle
module mmio_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic             push_ok, pop_ok;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(push_ok);
            rp  <= rp + AW'(pop_ok);
            cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= din;
    end
endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO decode, UART RX FIFO/TX holding register, perf counters, registered load data
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int RX_DEPTH = 4,
    parameter int ADDR_MSB = 31
) (
    input logic               clk,
    input logic               rst,
    mmio_responder_if.slave   bus
);
    tx_state_t   tx_state, tx_state_n;
    logic [7:0]  off, rx_head, tx_byte;
    logic [31:0] cyc, instr, rdata;
    logic        hit, ld, st, tx_load, tx_valid, rx_full, rx_empty, clr;
    logic        unused_bits;
    assign unused_bits = ^{bus.addr, bus.wdata};
    assign off = bus.addr[7:0];
    assign hit = bus.req_valid & is_mmio(bus.addr, ADDR_MSB);
    // a combined re/we access behaves as a load only
    assign ld  = hit & bus.re;
    assign st  = hit & bus.we & ~bus.re;
    assign clr = st & (off == OFF_CLR);
    mmio_rx_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.rx_data_valid),
        .din   (bus.rx_data),
        .pop   (ld & (off == OFF_RX)),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );
    assign bus.rx_data_ready = ~rx_full;
    assign tx_valid          = tx_state == TX_PEND;
    assign bus.tx_data_valid = tx_valid;
    assign bus.tx_data       = tx_byte;
    always_comb begin
        tx_state_n = tx_state;
        tx_load    = (tx_state == TX_IDLE) & st & (off == OFF_TX);
        tx_state_n = tx_load ? TX_PEND : (tx_valid & bus.tx_data_ready) ? TX_IDLE : tx_state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_byte  <= '0;
        end else begin
            tx_state <= tx_state_n;
            if (tx_load) tx_byte <= bus.wdata[7:0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cyc   <= '0;
            instr <= '0;
        end else begin
            cyc   <= cyc + 32'd1;
            instr <= instr + 32'(bus.inst_retire);
        end
    end
    // read mux sees pre-update state, so a load returns values from before its own side effects
    always_comb begin
        rdata = '0;
        rdata[ST_TX_READY]    = (off == OFF_STATUS) & ~tx_valid;
        rdata[ST_RX_NONEMPTY] = (off == OFF_STATUS) & ~rx_empty;
        rdata = (off == OFF_RX)    ? (rx_empty ? 32'd0 : {24'd0, rx_head}) :
                (off == OFF_CYC)   ? cyc :
                (off == OFF_INSTR) ? instr : rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) bus.dout <= '0;
        else if (ld) bus.dout <= rdata;
    end
endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: scoreboard-checked directed test of the MMIO responder
module tb_mmio_responder;
    import mmio_responder_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    always #5 clk = ~clk;
    mmio_responder_if bus();
    mmio_responder #(.RX_DEPTH(4), .ADDR_MSB(31)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // one bus cycle starting at a negedge; a load's expectation is scored one cycle later
    task automatic access(input logic v, input logic r, input logic w, input logic [7:0] off,
                          input logic [31:0] wd, input logic [31:0] exp, input string tag);
        bus.req_valid = v;
        bus.re        = r;
        bus.we        = w;
        bus.addr      = {24'h800000, off};
        bus.wdata     = wd;
        if (r) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.re        = 1'b0;
        bus.we        = 1'b0;
        if (exp_q.size() != 0) check(tag_q.pop_front(), bus.dout, exp_q.pop_front());
    endtask
    task automatic push_rx(input logic [7:0] b);
        bus.rx_data_valid = 1'b1;
        bus.rx_data       = b;
        @(negedge clk);
        bus.rx_data_valid = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        bus.req_valid = 0; bus.addr = 0; bus.re = 0; bus.we = 0; bus.wdata = 0;
        bus.inst_retire = 0; bus.rx_data = 0; bus.rx_data_valid = 0; bus.tx_data_ready = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_dout", bus.dout, 0);
        check("rst_rx_ready", 32'(bus.rx_data_ready), 1);
        check("rst_tx_valid", 32'(bus.tx_data_valid), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        access(1, 1, 0, OFF_STATUS, 0, 32'h1, "status_reset");
        push_rx(8'h41);
        push_rx(8'h42);
        access(1, 1, 0, OFF_RX, 0, 32'h41, "rx_first");
        access(1, 1, 0, OFF_RX, 0, 32'h42, "rx_second");
        access(1, 1, 0, OFF_RX, 0, 32'h0, "rx_empty_load");
        access(1, 1, 0, OFF_STATUS, 0, 32'h1, "status_rx_empty");
        for (int i = 1; i <= 4; i++) push_rx(8'(i));
        check("full_ready", 32'(bus.rx_data_ready), 0);
        access(1, 1, 0, OFF_STATUS, 0, 32'h3, "status_full");
        bus.rx_data_valid = 1'b1;
        bus.rx_data       = 8'h55;
        access(1, 1, 0, OFF_RX, 0, 32'h1, "full_pop_push");
        bus.rx_data_valid = 1'b0;
        check("still_full", 32'(bus.rx_data_ready), 0);
        access(1, 1, 0, OFF_RX, 0, 32'h2, "drain_2");
        access(1, 1, 0, OFF_RX, 0, 32'h3, "drain_3");
        access(1, 1, 0, OFF_RX, 0, 32'h4, "drain_4");
        access(1, 1, 0, OFF_RX, 0, 32'h55, "drain_55");
        check("drained_ready", 32'(bus.rx_data_ready), 1);
        push_rx(8'h77);
        access(0, 1, 0, OFF_RX, 0, 32'h55, "noreq_hold");
        access(1, 1, 0, OFF_RX, 0, 32'h77, "noreq_no_pop");
        access(1, 1, 0, 8'h0C, 0, 32'h0, "unmapped_load");
        access(1, 0, 1, OFF_TX, 32'hAB5A, 0, "tx_store");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("tx_hold_valid", 32'(bus.tx_data_valid), 1);
            check("tx_hold_data", 32'(bus.tx_data), 32'h5A);
        end
        access(1, 1, 0, OFF_STATUS, 0, 32'h0, "status_tx_busy");
        access(1, 0, 1, OFF_TX, 32'h11, 0, "tx_drop");
        check("tx_drop_data", 32'(bus.tx_data), 32'h5A);
        bus.tx_data_ready = 1'b1;
        @(negedge clk);
        bus.tx_data_ready = 1'b0;
        check("tx_done", 32'(bus.tx_data_valid), 0);
        check("tx_done_data", 32'(bus.tx_data), 32'h5A);
        access(1, 1, 1, OFF_TX, 32'h99, 32'h0, "re_we_load");
        check("re_we_no_tx", 32'(bus.tx_data_valid), 0);
        access(0, 0, 1, OFF_TX, 32'h98, 0, "noreq_store");
        check("noreq_no_tx", 32'(bus.tx_data_valid), 0);
        access(1, 0, 1, OFF_CLR, 0, 0, "clr0");
        for (int i = 0; i < 10; i++) begin
            bus.inst_retire = (i == 2 || i == 5 || i == 8);
            @(negedge clk);
        end
        bus.inst_retire = 1'b0;
        access(1, 1, 0, OFF_INSTR, 0, 32'd3, "instr_count");
        access(1, 1, 0, OFF_CYC, 0, 32'd11, "cyc_count");
        bus.inst_retire = 1'b1;
        access(1, 0, 1, OFF_CLR, 0, 0, "clr_retire");
        bus.inst_retire = 1'b0;
        access(1, 1, 0, OFF_CYC, 0, 32'd0, "cyc_cleared");
        access(1, 1, 0, OFF_INSTR, 0, 32'd0, "instr_cleared");
        for (int i = 0; i < 4; i++) push_rx(8'hC0 + 8'(i));
        access(1, 0, 1, OFF_TX, 32'h33, 0, "tx_before_rst");
        access(1, 1, 0, OFF_STATUS, 0, 32'h2, "status_pre_rst");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_dout", bus.dout, 0);
        check("rst2_rx_ready", 32'(bus.rx_data_ready), 1);
        check("rst2_tx_valid", 32'(bus.tx_data_valid), 0);
        check("rst2_tx_data", 32'(bus.tx_data), 0);
        access(1, 1, 0, OFF_RX, 0, 32'h0, "rst2_rx_empty");
        access(1, 1, 0, OFF_STATUS, 0, 32'h1, "rst2_status");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
